// File: rtl/main_mem_ctrl.sv
// Fixed-latency 1024x10 main memory controller behind the cache miss path.
// Define MAIN_MEM_BURST_EN to answer reads with a two-beat, pair-aligned burst.
module main_mem_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_req,
  input  logic       mem_we,
  input  logic [9:0] mem_addr,
  input  logic [9:0] mem_wdata,
  output logic       mem_busy,
  output logic       mem_ack,
  output logic [9:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
`ifdef MAIN_MEM_BURST_EN
  localparam logic [1:0] RESP2 = 2'd3;
`endif

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  logic [9:0] mem [1024];

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q;
  logic [9:0] addr_q, wdata_q;
  logic       accept;
  logic [9:0] rd_addr;

  // The final response cycle also returns to IDLE, so a request present then is taken
  // at the same edge; the earliest next accept is one edge after the last ack cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: accept = mem_req;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
`ifdef MAIN_MEM_BURST_EN
        if (!we_q) begin
          state_d = RESP2;
        end else begin
          accept  = mem_req;
          state_d = IDLE;
        end
`else
        accept  = mem_req;
        state_d = IDLE;
`endif
      end
      default: begin
        accept  = mem_req;
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      state_d = WAIT;
      cnt_d   = CntLoad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 10'h000;
      wdata_q <= 10'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  // Commit happens on the WAIT->RESP edge; reset forces IDLE, so aborted writes never land.
  always_ff @(posedge clk) begin
    if (state_q == WAIT && cnt_q == 4'd0 && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_comb begin
`ifdef MAIN_MEM_BURST_EN
    rd_addr = {addr_q[9:1], (state_q == RESP2)};
    mem_ack = (state_q == RESP) || (state_q == RESP2);
`else
    rd_addr = addr_q;
    mem_ack = (state_q == RESP);
`endif
    mem_busy  = (state_q != IDLE);
    mem_rdata = (mem_ack && !we_q) ? mem[rd_addr] : 10'h000;
  end

endmodule
